apb_spi_reg_fifo: RTL and testbench

APB slave front-end of the SPI master: it terminates the transfers driven by the APB master agent, holds the SPI control and clock-divider registers, and buffers transmit and receive words in two synchronous FIFOs. The SPI shift engine connects through valid/ready streams. This block is the direct downstream consumer of every APB transfer the master issues in the SPI master environment.

---
 rtl/apb_spi_reg_fifo_pkg.sv | 24 ++
 rtl/apb_spi_reg_fifo_if.sv | 26 ++
 rtl/apb_spi_reg_fifo_fifo.sv | 67 ++++++
 rtl/apb_spi_reg_fifo.sv | 193 +++++++++++++++++++
 tb/tb_apb_spi_reg_fifo.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_spi_reg_fifo_pkg.sv
// Shared constants and types for the APB front-end of the SPI master.
package apb_spi_reg_fifo_pkg;

    localparam int unsigned LOG_BUFFER_DEPTH = 1;

    localparam logic [4:0] CTRL_OFFSET   = 5'h00;
    localparam logic [4:0] CLKDIV_OFFSET = 5'h04;
    localparam logic [4:0] TXFIFO_OFFSET = 5'h08;
    localparam logic [4:0] RXFIFO_OFFSET = 5'h0C;
    localparam logic [4:0] STATUS_OFFSET = 5'h10;

    localparam int unsigned CTRL_SPI_EN_BIT    = 0;
    localparam int unsigned CTRL_TX_FLUSH_BIT  = 1;
    localparam int unsigned CTRL_RX_FLUSH_BIT  = 2;
    localparam int unsigned CTRL_RX_IRQ_EN_BIT = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT_STATE
    } apb_fsm_state_e;

endpackage

// File: rtl/apb_spi_reg_fifo_if.sv
// APB bus bundle between the APB master agent and the SPI register front-end.
interface apb_spi_reg_fifo_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_spi_reg_fifo_fifo.sv
// Synchronous FIFO with flush; push on full and pop on empty are ignored.
module spi_sync_fifo #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned LOG_BUFFER_DEPTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      pop,
    input  logic                      flush,
    output logic [DATA_WIDTH-1:0]     head,
    output logic                      full,
    output logic                      empty,
    output logic [LOG_BUFFER_DEPTH:0] count
);
    localparam int unsigned DEPTH = 1 << LOG_BUFFER_DEPTH;

    logic [DATA_WIDTH-1:0]       mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]       mem_d [DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOG_BUFFER_DEPTH:0]   count_q, count_d;
    logic                        push_ok, pop_ok;

    assign full  = (count_q == (LOG_BUFFER_DEPTH+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        // Flush overrides any same-cycle push or pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/apb_spi_reg_fifo.sv
// APB slave holding SPI CTRL/CLKDIV registers plus TX/RX FIFOs.
// Define APB_SPI_WAIT_STATE_EN for one wait state per transfer with registered prdata/pslverr.
module apb_spi_reg_fifo #(
    parameter int unsigned ADDRESS_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned LOG_BUFFER_DEPTH = apb_spi_reg_fifo_pkg::LOG_BUFFER_DEPTH,
    parameter logic [7:0]  CLKDIV_RESET     = 8'd4
) (
    input  logic                  pclk,
    input  logic                  preset,
    apb_spi_reg_fifo_if.slave     apb,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  spi_en,
    output logic [7:0]            clk_div,
    output logic                  rx_irq
);
    import apb_spi_reg_fifo_pkg::*;

    apb_fsm_state_e            state_q, state_d;
    logic                      spi_en_q, spi_en_d, rx_irq_en_q, rx_irq_en_d;
    logic [7:0]                clk_div_q, clk_div_d;
    logic                      tx_full, tx_empty, rx_full, rx_empty;
    logic [LOG_BUFFER_DEPTH:0] tx_count, rx_count;
    logic [DATA_WIDTH-1:0]     rx_head, rdata_c, rdata_out;
    logic [4:0]                reg_offset;
    logic                      err_c, err_out, complete, commit;
    logic                      tx_push, rx_pop, tx_flush, rx_flush, ctrl_wr, clkdiv_wr;
    logic                      unused_bits;

    assign reg_offset  = {apb.paddr[4:2], 2'b00};
    assign unused_bits = ^{apb.pprot, apb.paddr[ADDRESS_WIDTH-1:5], apb.paddr[1:0],
                           apb.pstrb[DATA_WIDTH/8-1:1]};

    always_comb begin
        err_c   = 1'b0;
        rdata_c = '0;
        case (reg_offset)
            CTRL_OFFSET: begin
                rdata_c[CTRL_SPI_EN_BIT]    = spi_en_q;
                rdata_c[CTRL_RX_IRQ_EN_BIT] = rx_irq_en_q;
            end
            CLKDIV_OFFSET: rdata_c[7:0] = clk_div_q;
            TXFIFO_OFFSET: err_c = !apb.pwrite || tx_full;
            RXFIFO_OFFSET: begin
                err_c   = apb.pwrite || rx_empty;
                rdata_c = rx_head;
            end
            STATUS_OFFSET: begin
                err_c          = apb.pwrite;
                rdata_c[0]     = tx_full;
                rdata_c[1]     = tx_empty;
                rdata_c[2]     = rx_full;
                rdata_c[3]     = rx_empty;
                rdata_c[15:8]  = 8'(tx_count);
                rdata_c[23:16] = 8'(rx_count);
            end
            default: err_c = 1'b1;
        endcase
        if (err_c || apb.pwrite) rdata_c = '0;
    end

`ifdef APB_SPI_WAIT_STATE_EN
    localparam bit WAIT_EN = 1'b1;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;

    // Decode is captured in ACCESS; only APB itself can fill TX or drain RX, so it stays valid.
    assign complete  = (state_q == WAIT_STATE);
    assign err_out   = pslverr_q;
    assign rdata_out = prdata_q;

    always_comb begin
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        if (state_q == ACCESS) begin
            prdata_d  = rdata_c;
            pslverr_d = err_c;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end
`else
    localparam bit WAIT_EN = 1'b0;
    assign complete  = (state_q == ACCESS);
    assign err_out   = err_c;
    assign rdata_out = rdata_c;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (apb.psel && !apb.penable) state_d = SETUP;
            SETUP: begin
                if (!apb.psel)        state_d = IDLE;
                else if (apb.penable) state_d = ACCESS;
            end
            ACCESS: begin
                if (WAIT_EN)                           state_d = WAIT_STATE;
                else if (apb.psel && !apb.penable)     state_d = SETUP;
                else                                   state_d = IDLE;
            end
            WAIT_STATE: state_d = (apb.psel && !apb.penable) ? SETUP : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    assign commit    = complete && !err_out;
    assign ctrl_wr   = commit && apb.pwrite && (reg_offset == CTRL_OFFSET) && apb.pstrb[0];
    assign clkdiv_wr = commit && apb.pwrite && (reg_offset == CLKDIV_OFFSET) && apb.pstrb[0];
    assign tx_push   = commit && apb.pwrite && (reg_offset == TXFIFO_OFFSET);
    assign rx_pop    = commit && !apb.pwrite && (reg_offset == RXFIFO_OFFSET);
    assign tx_flush  = ctrl_wr && apb.pwdata[CTRL_TX_FLUSH_BIT];
    assign rx_flush  = ctrl_wr && apb.pwdata[CTRL_RX_FLUSH_BIT];

    always_comb begin
        spi_en_d    = spi_en_q;
        rx_irq_en_d = rx_irq_en_q;
        clk_div_d   = clk_div_q;
        if (ctrl_wr) begin
            spi_en_d    = apb.pwdata[CTRL_SPI_EN_BIT];
            rx_irq_en_d = apb.pwdata[CTRL_RX_IRQ_EN_BIT];
        end
        if (clkdiv_wr) clk_div_d = apb.pwdata[7:0];
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            spi_en_q    <= 1'b0;
            rx_irq_en_q <= 1'b0;
            clk_div_q   <= CLKDIV_RESET;
        end else begin
            state_q     <= state_d;
            spi_en_q    <= spi_en_d;
            rx_irq_en_q <= rx_irq_en_d;
            clk_div_q   <= clk_div_d;
        end
    end

    spi_sync_fifo #(
        .DATA_WIDTH       (DATA_WIDTH),
        .LOG_BUFFER_DEPTH (LOG_BUFFER_DEPTH)
    ) u_tx_fifo (
        .clk       (pclk),
        .rst       (preset),
        .push      (tx_push),
        .push_data (apb.pwdata),
        .pop       (tx_valid && tx_ready),
        .flush     (tx_flush),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    spi_sync_fifo #(
        .DATA_WIDTH       (DATA_WIDTH),
        .LOG_BUFFER_DEPTH (LOG_BUFFER_DEPTH)
    ) u_rx_fifo (
        .clk       (pclk),
        .rst       (preset),
        .push      (rx_valid && rx_ready),
        .push_data (rx_data),
        .pop       (rx_pop),
        .flush     (rx_flush),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign tx_valid    = !tx_empty;
    assign rx_ready    = !rx_full;
    assign spi_en      = spi_en_q;
    assign clk_div     = clk_div_q;
    assign rx_irq      = !rx_empty && rx_irq_en_q;
    assign apb.pready  = complete;
    assign apb.pslverr = complete && err_out;
    assign apb.prdata  = complete ? rdata_out : '0;
endmodule

// File: tb/tb_apb_spi_reg_fifo.sv
// Directed self-checking bench for apb_spi_reg_fifo.
module tb_apb_spi_reg_fifo;
    logic        pclk = 1'b0;
    logic        preset;
    logic [31:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, spi_en, rx_irq;
    logic [7:0]  clk_div;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] rd;
    logic        er;

    apb_spi_reg_fifo_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_spi_reg_fifo #(
        .ADDRESS_WIDTH    (32),
        .DATA_WIDTH       (32),
        .LOG_BUFFER_DEPTH (1),
        .CLKDIV_RESET     (8'd4)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .apb      (bus.slave),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .spi_en   (spi_en),
        .clk_div  (clk_div),
        .rx_irq   (rx_irq)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        int n;
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr; bus.pwdata = data; bus.pstrb = strb;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        n = 0;
        while (bus.pready !== 1'b1 && n < 8) begin
            @(posedge pclk); #1;
            n++;
        end
        checks++;
        if (bus.pready !== 1'b1) begin
            failures++;
            $display("FAIL apb_timeout addr=%h got pready=%b exp=1", addr, bus.pready);
        end
        rdata = bus.prdata;
        err   = bus.pslverr;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0;
        bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        checks++; if (bus.pready !== 1'b0) begin failures++; $display("FAIL rst_pready got=%b exp=0", bus.pready); end
        checks++; if (bus.pslverr !== 1'b0) begin failures++; $display("FAIL rst_pslverr got=%b exp=0", bus.pslverr); end
        checks++; if (bus.prdata !== 32'h0) begin failures++; $display("FAIL rst_prdata got=%h exp=0", bus.prdata); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); end
        checks++; if (spi_en !== 1'b0) begin failures++; $display("FAIL rst_spi_en got=%b exp=0", spi_en); end
        checks++; if (clk_div !== 8'h04) begin failures++; $display("FAIL rst_clk_div got=%h exp=04", clk_div); end
        checks++; if (rx_irq !== 1'b0) begin failures++; $display("FAIL rst_rx_irq got=%b exp=0", rx_irq); end
        apb_xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL rst_ctrl got=%h/%b exp=0/0", rd, er); end
        apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h4 || er !== 1'b0) begin failures++; $display("FAIL rst_clkdiv got=%h/%b exp=4/0", rd, er); end
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'hA || er !== 1'b0) begin failures++; $display("FAIL rst_status got=%h/%b exp=a/0", rd, er); end
    endtask

    task automatic test_clkdiv_strobe();
        apb_xfer(1'b1, 32'h04, 32'hABCD_1234, 4'b0001, rd, er);
        checks++; if (clk_div !== 8'h34 || er !== 1'b0) begin failures++; $display("FAIL clkdiv_wr got=%h/%b exp=34/0", clk_div, er); end
        apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h34) begin failures++; $display("FAIL clkdiv_rd got=%h exp=34", rd); end
        apb_xfer(1'b1, 32'h04, 32'h0000_7777, 4'b0010, rd, er);
        checks++; if (clk_div !== 8'h34) begin failures++; $display("FAIL clkdiv_lane got=%h exp=34", clk_div); end
    endtask

    task automatic test_ctrl();
        apb_xfer(1'b1, 32'h00, 32'h0000_000F, 4'hF, rd, er);
        checks++; if (spi_en !== 1'b1) begin failures++; $display("FAIL ctrl_spi_en got=%b exp=1", spi_en); end
        apb_xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h9) begin failures++; $display("FAIL ctrl_rd got=%h exp=9", rd); end
    endtask

    task automatic test_tx_fifo();
        tx_ready = 1'b0;
        apb_xfer(1'b1, 32'h08, 32'h11, 4'h0, rd, er);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL tx_push1 got=%b exp=0", er); end
        apb_xfer(1'b1, 32'h08, 32'h22, 4'h0, rd, er);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL tx_push2 got=%b exp=0", er); end
        apb_xfer(1'b1, 32'h08, 32'h33, 4'hF, rd, er);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL tx_push_full got=%b exp=1", er); end
        checks++; if (tx_data !== 32'h11 || tx_valid !== 1'b1) begin failures++; $display("FAIL tx_head got=%h/%b exp=11/1", tx_data, tx_valid); end
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h0000_0209) begin failures++; $display("FAIL tx_status got=%h exp=00000209", rd); end
        tx_ready = 1'b1;
        @(posedge pclk); #1;
        checks++; if (tx_data !== 32'h22 || tx_valid !== 1'b1) begin failures++; $display("FAIL tx_pop1 got=%h/%b exp=22/1", tx_data, tx_valid); end
        @(posedge pclk); #1;
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_pop2 got=%b exp=0", tx_valid); end
    endtask

    task automatic test_rx_fifo();
        rx_valid = 1'b1; rx_data = 32'hA5;
        @(posedge pclk); #1;
        rx_data = 32'h5A;
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rx_ready1 got=%b exp=1", rx_ready); end
        @(posedge pclk); #1;
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0 || rx_irq !== 1'b1) begin failures++; $display("FAIL rx_full got=%b/%b exp=0/1", rx_ready, rx_irq); end
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h0002_0006) begin failures++; $display("FAIL rx_status got=%h exp=00020006", rd); end
        apb_xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'hA5 || er !== 1'b0) begin failures++; $display("FAIL rx_pop1 got=%h/%b exp=a5/0", rd, er); end
        apb_xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h5A || er !== 1'b0) begin failures++; $display("FAIL rx_pop2 got=%h/%b exp=5a/0", rd, er); end
        apb_xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL rx_pop_empty got=%h/%b exp=0/1", rd, er); end
        checks++; if (rx_irq !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL rx_drained got=%b/%b exp=0/1", rx_irq, rx_ready); end
    endtask

    task automatic test_errors();
        apb_xfer(1'b0, 32'h18, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL err_unmapped got=%h/%b exp=0/1", rd, er); end
        apb_xfer(1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rd, er);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_wr_status got=%b exp=1", er); end
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL err_rd_tx got=%h/%b exp=0/1", rd, er); end
        apb_xfer(1'b1, 32'h0C, 32'h77, 4'hF, rd, er);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_wr_rx got=%b exp=1", er); end
        apb_xfer(1'b1, 32'h1C, 32'h0, 4'hF, rd, er);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_wr_unmapped got=%b exp=1", er); end
        apb_xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h9) begin failures++; $display("FAIL err_ctrl_kept got=%h exp=9", rd); end
        apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h34) begin failures++; $display("FAIL err_clkdiv_kept got=%h exp=34", rd); end
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'hA) begin failures++; $display("FAIL err_status_kept got=%h exp=a", rd); end
    endtask

    task automatic test_flush();
        apb_xfer(1'b1, 32'h08, 32'h44, 4'hF, rd, er);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 32'h44) begin failures++; $display("FAIL flush_pre got=%b/%h exp=1/44", tx_valid, tx_data); end
        apb_xfer(1'b1, 32'h00, 32'h0000_000B, 4'h1, rd, er);
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL flush_tx got=%b exp=0", tx_valid); end
        apb_xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h9) begin failures++; $display("FAIL flush_ctrl got=%h exp=9", rd); end
    endtask

    task automatic test_reset_mid();
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h08; bus.pwdata = 32'h55; bus.pstrb = 4'hF;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        checks++; if (bus.pready !== 1'b0) begin failures++; $display("FAIL mid_pready got=%b exp=0", bus.pready); end
        checks++; if (tx_valid !== 1'b0 || spi_en !== 1'b0 || clk_div !== 8'h04) begin
            failures++; $display("FAIL mid_state got=%b/%b/%h exp=0/0/04", tx_valid, spi_en, clk_div); end
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'hA) begin failures++; $display("FAIL mid_status got=%h exp=a", rd); end
    endtask

    initial begin
        test_reset();
        test_clkdiv_strobe();
        test_ctrl();
        test_tx_fifo();
        test_rx_fifo();
        test_errors();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
